ras: RTL and testbench

RAS -- requirements
Module: ras

---
 rtl/core_types_pkg.sv | 22 ++
 rtl/ras.sv | 120 ++++++++++++
 tb/tb_ras.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: return-address-stack sizing, reset PC and the RAS operation decode.
package core_types_pkg;

    localparam int unsigned RAS_ENTRIES      = 8;
    localparam int unsigned RAS_INDEX_WIDTH  = 3;
    localparam int unsigned RAS_TARGET_WIDTH = 31;

    localparam logic [31:0] INIT_PC = 32'h8000_0000;

    // {push, pop} request pair seen by the stack in one cycle
    typedef enum logic [1:0] {
        RAS_OP_NONE = 2'b00,
        RAS_OP_POP  = 2'b01,
        RAS_OP_PUSH = 2'b10,
        RAS_OP_SWAP = 2'b11
    } ras_op_e;

    function automatic ras_op_e ras_decode(input logic push, input logic pop);
        return ras_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/ras.sv
// Return address stack: circular target array with a top pointer and checkpoint restore.
// Optional occupancy tracking and ras_empty output under LOROF_RAS_EMPTY_DETECT_EN.
module ras
    import core_types_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_pc,
    input  logic                        ret_req_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    input  logic                        update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index
`ifdef LOROF_RAS_EMPTY_DETECT_EN
    ,
    output logic                        ras_empty
`endif
);

    localparam logic [RAS_TARGET_WIDTH-1:0] INIT_TARGET = INIT_PC[31:1];

    logic [RAS_TARGET_WIDTH-1:0] array_q [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  top_q, top_d;
    logic [RAS_INDEX_WIDTH-1:0]  top_inc, top_dec;
    logic [RAS_INDEX_WIDTH-1:0]  wr_idx;
    logic                        wr_en;
    ras_op_e                     op;

`ifdef LOROF_RAS_EMPTY_DETECT_EN
    localparam int unsigned             COUNT_WIDTH = 4;
    localparam logic [COUNT_WIDTH-1:0]  COUNT_FULL  = COUNT_WIDTH'(RAS_ENTRIES);

    logic [COUNT_WIDTH-1:0] count_q, count_d;
`endif

    // Index width equals log2(depth), so natural wrap gives modulo-depth arithmetic
    assign top_inc = RAS_INDEX_WIDTH'(top_q + 1'b1);
    assign top_dec = RAS_INDEX_WIDTH'(top_q - 1'b1);
    assign op      = ras_decode(link_valid, ret_req_valid);

    always_comb begin
        top_d  = top_q;
        wr_en  = 1'b0;
        wr_idx = top_q;
`ifdef LOROF_RAS_EMPTY_DETECT_EN
        count_d = count_q;
`endif
        if (update_valid) begin
            // Restore wins over any same-cycle push/pop; occupancy is unknown so assume full
            top_d = update_ras_index;
`ifdef LOROF_RAS_EMPTY_DETECT_EN
            count_d = COUNT_FULL;
`endif
        end else begin
            unique case (op)
                RAS_OP_PUSH: begin
                    wr_en  = 1'b1;
                    wr_idx = top_inc;
                    top_d  = top_inc;
`ifdef LOROF_RAS_EMPTY_DETECT_EN
                    if (count_q != COUNT_FULL) begin
                        count_d = COUNT_WIDTH'(count_q + 1'b1);
                    end
`endif
                end
                RAS_OP_POP: begin
`ifdef LOROF_RAS_EMPTY_DETECT_EN
                    if (count_q != '0) begin
                        top_d   = top_dec;
                        count_d = COUNT_WIDTH'(count_q - 1'b1);
                    end
`else
                    top_d = top_dec;
`endif
                end
                RAS_OP_SWAP: begin
                    wr_en  = 1'b1;
                    wr_idx = top_q;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            top_q <= '0;
        end else begin
            top_q <= top_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < RAS_ENTRIES; i++) begin
                array_q[i] <= INIT_TARGET;
            end
        end else if (wr_en) begin
            array_q[wr_idx] <= link_pc;
        end
    end

`ifdef LOROF_RAS_EMPTY_DETECT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign ras_empty = (count_q == '0);
`endif

    assign ret_target = array_q[top_q];
    assign ras_index  = top_q;

endmodule

// File: tb/tb_ras.sv
// Scoreboard bench for ras: driver updates a queue-free reference model and pushes expectations;
// a negedge monitor pops and compares. Honours LOROF_RAS_EMPTY_DETECT_EN.
module tb_ras;
    import core_types_pkg::*;

    localparam logic [30:0] INIT_T = 31'h4000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        link_valid;
    logic [30:0] link_pc;
    logic        ret_req_valid;
    logic [30:0] ret_target;
    logic [2:0]  ras_index;
    logic        update_valid;
    logic [2:0]  update_ras_index;
`ifdef LOROF_RAS_EMPTY_DETECT_EN
    logic        ras_empty;
`endif

    ras dut (
        .CLK              (CLK),
        .RST              (RST),
        .link_valid       (link_valid),
        .link_pc          (link_pc),
        .ret_req_valid    (ret_req_valid),
        .ret_target       (ret_target),
        .ras_index        (ras_index),
        .update_valid     (update_valid),
        .update_ras_index (update_ras_index)
`ifdef LOROF_RAS_EMPTY_DETECT_EN
        ,
        .ras_empty        (ras_empty)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  idx;
        logic [30:0] tgt;
        logic        empty;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference stack: plain array, integer top, integer occupancy
    logic [30:0] m_arr [8];
    int          m_top;
    int          m_cnt;

    task automatic tally(input string name, input bit ok, input logic [2:0] ai, input logic [30:0] at,
                         input logic [2:0] ei, input logic [30:0] et);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got idx=%0d tgt=%h, want idx=%0d tgt=%h", name, ai, at, ei, et);
        end
    endtask

    task automatic check(input string name, input logic [2:0] ei, input logic [30:0] et);
        tally(name, (ras_index === ei) && (ret_target === et), ras_index, ret_target, ei, et);
    endtask

    task automatic check_empty(input string name, input logic e);
`ifdef LOROF_RAS_EMPTY_DETECT_EN
        n_cmp++;
        if (ras_empty !== e) begin
            n_bad++;
            $display("FAIL %s: got ras_empty=%b, want %b", name, ras_empty, e);
        end
`else
        if (e === 1'bx) $display("unused %s", name);
`endif
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_arr[i] = INIT_T;
        m_top = 0;
        m_cnt = 0;
    endtask

    task automatic m_step(input bit push, input bit pop, input bit upd, input int idx, input logic [30:0] pc);
        if (upd) begin
            m_top = idx;
            m_cnt = 8;
        end else if (push && pop) begin
            m_arr[m_top] = pc;
        end else if (push) begin
            m_top = (m_top + 1) % 8;
            m_arr[m_top] = pc;
            if (m_cnt < 8) m_cnt++;
        end else if (pop) begin
`ifdef LOROF_RAS_EMPTY_DETECT_EN
            if (m_cnt > 0) begin
                m_top = (m_top + 7) % 8;
                m_cnt--;
            end
`else
            m_top = (m_top + 7) % 8;
`endif
        end
    endtask

    task automatic idle();
        link_valid       = 1'b0;
        link_pc          = '0;
        ret_req_valid    = 1'b0;
        update_valid     = 1'b0;
        update_ras_index = '0;
    endtask

    // One request cycle; also confirms outputs hold pre-edge state while inputs are applied
    task automatic step(input bit push, input bit pop, input bit upd, input int idx, input logic [30:0] pc);
        exp_t e;
        @(negedge CLK);
        link_valid       = push;
        ret_req_valid    = pop;
        update_valid     = upd;
        update_ras_index = 3'(idx);
        link_pc          = pc;
        #1;
        check("comb_hold", 3'(m_top), m_arr[m_top]);
        @(posedge CLK);
        #1;
        m_step(push, pop, upd, idx, pc);
        e.idx   = 3'(m_top);
        e.tgt   = m_arr[m_top];
        e.empty = (m_cnt == 0);
        exp_q.push_back(e);
        idle();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        m_reset();
        check("rst_async", 3'd0, INIT_T);
        check_empty("rst_empty", 1'b1);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Monitor: outputs are always presented, so compare one expectation per falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tally("sb", (ras_index === e.idx) && (ret_target === e.tgt), ras_index, ret_target, e.idx, e.tgt);
`ifdef LOROF_RAS_EMPTY_DETECT_EN
                check_empty("sb_empty", e.empty);
`endif
            end
        end
    end

    initial begin
        RST = 1'b1;
        idle();
        m_reset();
        #1;
        check("reset", 3'd0, INIT_T);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("reset_release", 3'd0, INIT_T);

        // Two pushes then a pop
        step(1, 0, 0, 0, 31'h100);
        step(1, 0, 0, 0, 31'h200);
        check("push2", 3'd2, 31'h200);
        step(0, 1, 0, 0, 31'h0);
        check("pop1", 3'd1, 31'h100);

        // Overflow by one, then unwind through the wrap
        do_reset();
        for (int k = 1; k <= 9; k++) step(1, 0, 0, 0, 31'(k));
        check("overflow", 3'd1, 31'h9);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 0, 0, 31'h0);
            check("unwind", 3'((9 - k) % 8), (k < 8) ? 31'(9 - k) : 31'h9);
        end

        // Coroutine swap
        do_reset();
        step(1, 0, 0, 0, 31'h300);
        check("push_x", 3'd1, 31'h300);
        step(1, 1, 0, 0, 31'h400);
        check("swap", 3'd1, 31'h400);

        // Restore overrides same-cycle push
        do_reset();
        step(1, 0, 0, 0, 31'h11);
        step(1, 0, 0, 0, 31'h22);
        step(1, 0, 0, 0, 31'h33);
        check("three_push", 3'd3, 31'h33);
        step(1, 0, 1, 1, 31'h44);
        check("restore", 3'd1, 31'h11);
        check_empty("restore_full", 1'b0);

        // Pop on an empty stack
        do_reset();
        step(0, 1, 0, 0, 31'h0);
`ifdef LOROF_RAS_EMPTY_DETECT_EN
        check("empty_pop", 3'd0, INIT_T);
        check_empty("empty_pop_flag", 1'b1);
        step(1, 0, 0, 0, 31'h77);
        check("empty_push", 3'd1, 31'h77);
        check_empty("empty_push_flag", 1'b0);
`else
        check("empty_pop", 3'd7, INIT_T);
`endif

        // Reset mid-request discards the in-flight push immediately
        step(1, 0, 0, 0, 31'h66);
        @(negedge CLK);
        link_valid = 1'b1;
        link_pc    = 31'h55;
        #2;
        RST = 1'b1;
        #1;
        m_reset();
        check("mid_reset", 3'd0, INIT_T);
        @(posedge CLK);
        #1;
        check("mid_reset_edge", 3'd0, INIT_T);
        idle();
        @(negedge CLK);
        RST = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit upd;
            upd = ($urandom_range(0, 99) < 8);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), upd,
                 int'($urandom_range(0, 7)), 31'($urandom));
        end

        repeat (3) @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
